dmem_responder: RTL and testbench

Memory-side responder for the core's load/store unit: accepts one data-memory request at a time over a valid/ready request channel, applies a configurable number of wait states, then commits the store or returns load data over a valid/ready response channel. It sits between the core's LSU and a byte-addressed little-endian data array and replaces the core's direct single-cycle RAM access with a handshaked, latency-tolerant path. Errors cover misaligned, out-of-range and illegal-size requests.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 39 +++
 rtl/dmem_responder.sv | 96 +++++++++
 tb/tb_dmem_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and request decode helpers for dmem_responder
package dmem_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  function automatic logic [2:0] acc_len(input logic [1:0] size);
    return size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : 3'd4;
  endfunction

  function automatic logic [3:0] acc_be(input logic [1:0] size);
    return size == SZ_BYTE ? 4'b0001 : size == SZ_HALF ? 4'b0011 : 4'b1111;
  endfunction

  // 33-bit sum so addresses near 2^32 cannot wrap past the range check
  function automatic logic acc_err(input logic [31:0] addr, input logic [1:0] size, input logic [32:0] mem_size);
    return size == 2'd3 || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'd0) ||
           ({1'b0, addr} + 33'(acc_len(size)) > mem_size);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: little-endian byte array, byte-enabled write, registered read; DMEM_DBG_PORT_EN adds a combinational debug read
module dmem_array #(
  parameter int MEM_SIZE = 'h2024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
`ifdef DMEM_DBG_PORT_EN
  ,
  input  logic [31:0] dbg_addr,
  output logic [31:0] dbg_rd
`endif
);
  localparam int AW = $clog2(MEM_SIZE);
  logic [7:0] mem [MEM_SIZE];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[AW'(addr + 32'(i))] <= wdata[8*i +: 8];
  end
  // disabled lanes and store/error responses load zero so rdata is clean
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re)
      for (int i = 0; i < 4; i++)
        rdata[8*i +: 8] <= (be[i] && !we) ? mem[AW'(addr + 32'(i))] : 8'h00;
  end
`ifdef DMEM_DBG_PORT_EN
  always_comb begin
    dbg_rd = '0;
    for (int i = 0; i < 4; i++)
      dbg_rd[8*i +: 8] = ({1'b0, dbg_addr} + 33'(i) < 33'(MEM_SIZE)) ? mem[AW'(dbg_addr + 32'(i))] : 8'h00;
  end
`endif
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory responder with wait states
// DMEM_DBG_PORT_EN exposes a combinational debug word read port
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_SIZE    = 'h2024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_DBG_PORT_EN
  ,
  input  logic [31:0] dbg_addr,
  output logic [31:0] dbg_rd
`endif
);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  state_e state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic l_we, c_we, accept, enter_resp, err;
  logic [1:0] l_size, c_size;
  logic [31:0] l_addr, l_wdata, c_addr, c_wdata;
  assign accept = state == IDLE && req_valid;
  // with zero wait states the request commits on its accept edge, before it is latched
  assign c_we    = state == IDLE ? req_we : l_we;
  assign c_size  = state == IDLE ? req_size : l_size;
  assign c_addr  = state == IDLE ? req_addr : l_addr;
  assign c_wdata = state == IDLE ? req_wdata : l_wdata;
  assign err = acc_err(c_addr, c_size, 33'(MEM_SIZE));
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        state_nx = WAIT_CYCLES == 0 ? RESP : WAIT;
        cnt_nx = WAIT_CYCLES > 0 ? CW'(WAIT_CYCLES - 1) : '0;
        enter_resp = WAIT_CYCLES == 0;
      end
      WAIT: if (cnt == '0) begin
        state_nx = RESP;
        enter_resp = 1'b1;
      end else cnt_nx = cnt - 1'b1;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      l_we <= 1'b0;
      l_size <= '0;
      l_addr <= '0;
      l_wdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept) begin
        l_we <= req_we;
        l_size <= req_size;
        l_addr <= req_addr;
        l_wdata <= req_wdata;
      end
      if (enter_resp) rsp_err <= err;
    end
  end
  dmem_array #(.MEM_SIZE(MEM_SIZE)) u_array (
    .clk(clk),
    .rst(rst),
    .we(enter_resp && c_we && !err),
    .re(enter_resp),
    .be(err ? 4'h0 : acc_be(c_size)),
    .addr(c_addr),
    .wdata(c_wdata),
    .rdata(rsp_rdata)
`ifdef DMEM_DBG_PORT_EN
    ,
    .dbg_addr(dbg_addr),
    .dbg_rd(dbg_rd)
`endif
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with one-wait and zero-wait instances
module tb_dmem_responder;
  localparam int MS = 'h2024;
  localparam int W = 1;
  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
  } op_t;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0, rsp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0, dbg_addr = 0;
  logic [1:0] req_size = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, dbg_rd;
  logic z_req_valid = 0, z_req_we = 0, z_rsp_ready = 1;
  logic [31:0] z_req_addr = 0, z_req_wdata = 0, z_dbg_addr = 0;
  logic [1:0] z_req_size = 0;
  logic z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata, z_dbg_rd;
  int checks = 0, failures = 0, edges = 0;
  logic [32:0] sb[$];
  logic [31:0] got_rd;
  logic got_err;
  int got_lat, got_acc;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  dmem_responder #(.MEM_SIZE(MS), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_DBG_PORT_EN
    , .dbg_addr(dbg_addr), .dbg_rd(dbg_rd)
`endif
  );

  dmem_responder #(.MEM_SIZE(MS), .WAIT_CYCLES(0)) u_zero (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_size(z_req_size), .req_wdata(z_req_wdata), .rsp_valid(z_rsp_valid),
    .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
`ifdef DMEM_DBG_PORT_EN
    , .dbg_addr(z_dbg_addr), .dbg_rd(z_dbg_rd)
`endif
  );

`ifndef DMEM_DBG_PORT_EN
  assign dbg_rd = '0;
  assign z_dbg_rd = '0;
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // acc is the edge count at the start of the cycle in which the request is accepted
  task automatic send(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                      output int acc, output bit ok);
    ok = 0;
    acc = 0;
    @(negedge clk);
    req_we = we; req_addr = a; req_size = sz; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_ready) begin
        acc = edges;
        ok = 1;
      end
      @(posedge clk); #1;
      if (!ok) @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic recv(output logic [31:0] rd, output logic err, output int rise, output bit ok);
    ok = 0; rd = '0; err = 0; rise = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rd = rsp_rdata;
        err = rsp_err;
        rise = edges;
        ok = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                        input logic [31:0] e_rd, input logic e_err);
    bit ok1, ok2;
    int acc, rise;
    sb.push_back({e_err, e_rd});
    rsp_ready = 1'b1;
    send(we, a, sz, wd, acc, ok1);
    recv(got_rd, got_err, rise, ok2);
    got_lat = rise - acc;
    got_acc = acc;
    checks++;
    if (!(ok1 && ok2)) begin
      failures++;
      $display("FAIL handshake_timeout addr=%h accepted=%0b responded=%0b expected 1 1", a, ok1, ok2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_outputs ready=%b valid=%b err=%b rdata=%h expected 1 0 0 00000000",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, z_req_ready, z_rsp_valid} !== 4'b1010) begin
      failures++;
      $display("FAIL post_reset_idle ready=%b valid=%b z_ready=%b z_valid=%b expected 1 0 1 0",
               req_ready, rsp_valid, z_req_ready, z_rsp_valid);
    end
  endtask

  task automatic test_word();
    logic [32:0] e;
    op_t t [2] = '{'{1'b1, 32'd12, 2'd2, 32'h1234_5678, 32'h0, 1'b0},
                   '{1'b0, 32'd12, 2'd2, 32'h0, 32'h1234_5678, 1'b0}};
    foreach (t[i]) begin
      run_op(t[i].we, t[i].a, t[i].sz, t[i].wd, t[i].erd, t[i].eerr);
      e = sb.pop_front();
      checks++;
      if ({got_err, got_rd} !== e) begin
        failures++;
        $display("FAIL word_op%0d err=%b rdata=%h expected err=%b rdata=%h", i, got_err, got_rd, e[32], e[31:0]);
      end
      checks++;
      if (got_lat !== W + 1) begin
        failures++;
        $display("FAIL word_latency%0d got %0d expected %0d", i, got_lat, W + 1);
      end
    end
`ifdef DMEM_DBG_PORT_EN
    dbg_addr = 32'd12;
    #1;
    checks++;
    if (dbg_rd !== 32'h1234_5678) begin
      failures++;
      $display("FAIL dbg_word12 got %h expected 12345678", dbg_rd);
    end
`endif
  endtask

  task automatic test_byte_half();
    logic [32:0] e;
    op_t t [4] = '{'{1'b1, 32'd13, 2'd0, 32'hFFFF_FFAB, 32'h0, 1'b0},
                   '{1'b0, 32'd12, 2'd1, 32'h0, 32'h0000_AB78, 1'b0},
                   '{1'b0, 32'd15, 2'd0, 32'h0, 32'h0000_0012, 1'b0},
                   '{1'b0, 32'd12, 2'd2, 32'h0, 32'h1234_AB78, 1'b0}};
    foreach (t[i]) begin
      run_op(t[i].we, t[i].a, t[i].sz, t[i].wd, t[i].erd, t[i].eerr);
      e = sb.pop_front();
      checks++;
      if ({got_err, got_rd} !== e) begin
        failures++;
        $display("FAIL byte_half_op%0d err=%b rdata=%h expected err=%b rdata=%h", i, got_err, got_rd, e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_errors();
    logic [32:0] e;
    op_t t [9] = '{'{1'b0, 32'd14, 2'd2, 32'h0, 32'h0, 1'b1},
                   '{1'b1, 32'd3, 2'd1, 32'hFFFF_FFFF, 32'h0, 1'b1},
                   '{1'b0, 32'd0, 2'd3, 32'h0, 32'h0, 1'b1},
                   '{1'b1, 32'(MS - 2), 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b1},
                   '{1'b0, 32'(MS), 2'd0, 32'h0, 32'h0, 1'b1},
                   '{1'b1, 32'(MS - 4), 2'd2, 32'hCAFE_F00D, 32'h0, 1'b0},
                   '{1'b0, 32'(MS - 4), 2'd2, 32'h0, 32'hCAFE_F00D, 1'b0},
                   '{1'b0, 32'(MS - 2), 2'd1, 32'h0, 32'h0000_CAFE, 1'b0},
                   '{1'b0, 32'd12, 2'd2, 32'h0, 32'h1234_AB78, 1'b0}};
    foreach (t[i]) begin
      run_op(t[i].we, t[i].a, t[i].sz, t[i].wd, t[i].erd, t[i].eerr);
      e = sb.pop_front();
      checks++;
      if ({got_err, got_rd} !== e) begin
        failures++;
        $display("FAIL error_case%0d err=%b rdata=%h expected err=%b rdata=%h", i, got_err, got_rd, e[32], e[31:0]);
      end
    end
`ifdef DMEM_DBG_PORT_EN
    dbg_addr = 32'(MS - 2);
    #1;
    checks++;
    if (dbg_rd !== 32'h0000_CAFE) begin
      failures++;
      $display("FAIL dbg_past_end got %h expected 0000cafe", dbg_rd);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    int acc1;
    run_op(1'b0, 32'd12, 2'd1, 32'h0, 32'h0000_AB78, 1'b0);
    acc1 = got_acc;
    e = sb.pop_front();
    checks++;
    if ({got_err, got_rd} !== e) begin
      failures++;
      $display("FAIL b2b_first err=%b rdata=%h expected err=%b rdata=%h", got_err, got_rd, e[32], e[31:0]);
    end
    run_op(1'b0, 32'd15, 2'd0, 32'h0, 32'h0000_0012, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({got_err, got_rd} !== e || got_acc - acc1 !== W + 2) begin
      failures++;
      $display("FAIL b2b_second err=%b rdata=%h period=%0d expected err=%b rdata=%h period=%0d",
               got_err, got_rd, got_acc - acc1, e[32], e[31:0], W + 2);
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] e;
    logic [31:0] hold;
    bit ok, seen;
    int acc, rise;
    rsp_ready = 1'b0;
    sb.push_back({1'b0, 32'h1234_AB78});
    send(1'b0, 32'd12, 2'd2, 32'h0, acc, ok);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    hold = rsp_rdata;
    e = sb.pop_front();
    checks++;
    if (!ok || !seen || {rsp_err, rsp_rdata} !== e) begin
      failures++;
      $display("FAIL bp_response accepted=%0b valid=%0b err=%b rdata=%h expected 1 1 err=%b rdata=%h",
               ok, seen, rsp_err, rsp_rdata, e[32], e[31:0]);
    end
    sb.push_back({1'b0, 32'h0000_0012});
    req_we = 1'b0; req_addr = 32'd15; req_size = 2'd0; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready} !== 2'b10 || rsp_rdata !== hold) begin
        failures++;
        $display("FAIL bp_hold%0d valid=%b ready=%b rdata=%h expected 1 0 %h", c, rsp_valid, req_ready, rsp_rdata, hold);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_release valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
    end
    acc = edges;
    @(posedge clk); #1;
    req_valid = 1'b0;
    recv(got_rd, got_err, rise, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || {got_err, got_rd} !== e || rise - acc !== W + 1) begin
      failures++;
      $display("FAIL bp_second ok=%0b err=%b rdata=%h lat=%0d expected 1 err=%b rdata=%h lat=%0d",
               ok, got_err, got_rd, rise - acc, e[32], e[31:0], W + 1);
    end
  endtask

  task automatic test_reset_midop();
    logic [32:0] e;
    bit ok;
    int acc;
    run_op(1'b1, 32'd8, 2'd2, 32'h0BAD_F00D, 32'h0, 1'b0);
    void'(sb.pop_front());
    send(1'b1, 32'd8, 2'd2, 32'hDEAD_BEEF, acc, ok);
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || {rsp_valid, req_ready, rsp_rdata} !== {1'b0, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL midop_reset accepted=%0b valid=%b ready=%b rdata=%h expected 1 0 1 00000000",
               ok, rsp_valid, req_ready, rsp_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef DMEM_DBG_PORT_EN
    dbg_addr = 32'd8;
    #1;
    checks++;
    if (dbg_rd !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL midop_dbg got %h expected 0badf00d", dbg_rd);
    end
`endif
    run_op(1'b0, 32'd8, 2'd2, 32'h0, 32'h0BAD_F00D, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({got_err, got_rd} !== e) begin
      failures++;
      $display("FAIL midop_word8 err=%b rdata=%h expected err=%b rdata=%h", got_err, got_rd, e[32], e[31:0]);
    end
  endtask

  task automatic test_zero_wait();
    logic [32:0] e;
    int acc;
    z_rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(i == 0 ? 33'h0 : {1'b0, 32'h0000_00FF});
      @(negedge clk);
      z_req_we = (i == 0); z_req_addr = 32'd0; z_req_size = 2'd2; z_req_wdata = 32'h0000_00FF; z_req_valid = 1'b1;
      acc = edges;
      checks++;
      if (z_req_ready !== 1'b1) begin
        failures++;
        $display("FAIL zero_ready%0d got %b expected 1", i, z_req_ready);
      end
      @(posedge clk); #1;
      z_req_valid = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (z_rsp_valid !== 1'b1 || {z_rsp_err, z_rsp_rdata} !== e || edges - acc !== 1) begin
        failures++;
        $display("FAIL zero_rsp%0d valid=%b err=%b rdata=%h lat=%0d expected 1 err=%b rdata=%h lat=1",
                 i, z_rsp_valid, z_rsp_err, z_rsp_rdata, edges - acc, e[32], e[31:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_zero_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
